// File: rtl/replica_exchange_test.sv
// Metropolis replica-exchange test for the pair (id, id+1), exp(-y) by streamed Taylor series.
// Define EXCHANGE_STAT_EN to add the test_cnt/acc_cnt decision counters.
package replica_pkg;
   localparam int unsigned replica_num = 4;
   typedef enum logic [1:0] {NONE = 2'd0, TWO = 2'd1, OR1 = 2'd2, ALL = 2'd3} com_t;
   typedef struct packed {
      com_t       com;
      logic [5:0] mode;
   } opt_t;
endpackage

module replica_exchange_test
   import replica_pkg::*;
#(
   parameter int unsigned id  = 0,
   parameter int unsigned E_W = 20
) (
   input  logic           clk,
   input  logic           reset,
   input  opt_t           opt,
   input  logic [E_W-1:0] self_energy,
   input  logic [E_W-1:0] folw_energy,
   input  logic [15:0]    delta_beta,
   input  logic [15:0]    rand_val,
   input  logic           exp_init,
   input  logic           exp_run,
   input  logic           exp_fin,
   input  logic [16:0]    exp_recip,
   output logic           out_exchange,
   output logic           busy
`ifdef EXCHANGE_STAT_EN
   ,
   output logic [15:0]    test_cnt,
   output logic [15:0]    acc_cnt
`endif
);

   localparam int unsigned PW = E_W + 16;
   localparam logic signed [28:0] ONE = 29'sh10000;

   typedef enum logic [2:0] {IDLE, LOAD, SERIES, DECIDE, HOLD} state_t;

   state_t state, state_next;

   logic [E_W-1:0]    e_self, e_folw, diff;
   logic [15:0]       db;
   logic [PW-1:0]     prod;
   logic [17:0]       y;
   logic signed [28:0] term, sum, t1, term_next, sum_next;
   logic signed [47:0] p1, p2;
   logic [4:0]        k;
   logic [15:0]       sum_clamped;
   logic              pair_active, fast_take, clamp_hit, fast, run_en, decision;
   logic              unused_opt;

   assign unused_opt = ^opt.mode;

   // Products are only ever positive in practice, but truncate toward zero for any sign.
   function automatic logic signed [28:0] trunc16(input logic signed [47:0] v);
      logic signed [47:0] mag;
      mag = v[47] ? -v : v;
      mag = mag >>> 16;
      return v[47] ? 29'(-mag) : 29'(mag);
   endfunction

   always_comb begin
      pair_active = 1'b0;
      if (id < replica_num - 1) begin
         case (opt.com)
            TWO:     pair_active = (id % 2 == 0);
            OR1:     pair_active = (id % 2 == 1);
            default: pair_active = 1'b0;
         endcase
      end
   end

   always_comb begin
      diff      = e_self - e_folw;
      prod      = {16'b0, diff} * {{E_W{1'b0}}, db};
      fast_take = (e_folw >= e_self);
      clamp_hit = |prod[PW-1:14];
      fast      = fast_take | clamp_hit;
   end

   // k holds terms already summed, so the current term index is k+1.
   always_comb begin
      p1        = {{19{term[28]}}, term} * {30'b0, y};
      t1        = trunc16(p1);
      p2        = {{19{t1[28]}}, t1} * {31'b0, exp_recip};
      term_next = trunc16(p2);
      sum_next  = k[0] ? (sum + term_next) : (sum - term_next);
      run_en    = (state == SERIES) && exp_run && (k != 5'd31);
   end

   always_comb begin
      if (sum[28])
         sum_clamped = '0;
      else if (|sum[27:16])
         sum_clamped = '1;
      else
         sum_clamped = sum[15:0];
      decision = (rand_val < sum_clamped);
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (exp_init) begin
         state_next = pair_active ? LOAD : IDLE;
      end else begin
         case (state)
            LOAD:    state_next = fast ? HOLD : SERIES;
            SERIES:  if (exp_fin) state_next = DECIDE;
            DECIDE:  state_next = HOLD;
            default: state_next = state;
         endcase
      end
   end

   assign busy = (state == LOAD) || (state == SERIES) || (state == DECIDE);

   always_ff @(posedge clk) begin
      if (reset) begin
         e_self       <= '0;
         e_folw       <= '0;
         db           <= '0;
         y            <= '0;
         term         <= '0;
         sum          <= '0;
         k            <= '0;
         out_exchange <= 1'b0;
      end else if (exp_init) begin
         out_exchange <= 1'b0;
         e_self       <= self_energy;
         e_folw       <= folw_energy;
         db           <= delta_beta;
      end else begin
         case (state)
            LOAD: begin
               if (fast) begin
                  out_exchange <= fast_take;
               end else begin
                  y    <= {prod[13:0], 4'b0000};
                  term <= ONE;
                  sum  <= ONE;
                  k    <= '0;
               end
            end
            SERIES: begin
               if (run_en) begin
                  term <= term_next;
                  sum  <= sum_next;
                  k    <= k + 5'd1;
               end
            end
            DECIDE:  out_exchange <= decision;
            default: ;
         endcase
      end
   end

`ifdef EXCHANGE_STAT_EN
   logic issue, issue_val;

   always_comb begin
      issue     = !exp_init && (((state == LOAD) && fast) || (state == DECIDE));
      issue_val = (state == LOAD) ? fast_take : decision;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         test_cnt <= '0;
         acc_cnt  <= '0;
      end else if (issue) begin
         if (test_cnt != '1)
            test_cnt <= test_cnt + 16'd1;
         if (issue_val && (acc_cnt != '1))
            acc_cnt <= acc_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_replica_exchange_test.sv
// Bench for replica_exchange_test: three instances (id 1, 2, 3) share stimulus and are
// checked against a plain-arithmetic Metropolis/Taylor reference model.
module tb_replica_exchange_test;
   import replica_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   opt_t        opt;
   logic [19:0] self_energy, folw_energy;
   logic [15:0] delta_beta, rand_val;
   logic        exp_init, exp_run, exp_fin;
   logic [16:0] exp_recip;
   logic [2:0]  outv, busyv;
`ifdef EXCHANGE_STAT_EN
   logic [15:0] tcnt [3];
   logic [15:0] acnt [3];
`endif

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      replica_exchange_test #(.id(g + 1), .E_W(20)) u_dut (
         .clk          (clk),
         .reset        (reset),
         .opt          (opt),
         .self_energy  (self_energy),
         .folw_energy  (folw_energy),
         .delta_beta   (delta_beta),
         .rand_val     (rand_val),
         .exp_init     (exp_init),
         .exp_run      (exp_run),
         .exp_fin      (exp_fin),
         .exp_recip    (exp_recip),
         .out_exchange (outv[g]),
         .busy         (busyv[g])
`ifdef EXCHANGE_STAT_EN
         ,
         .test_cnt     (tcnt[g]),
         .acc_cnt      (acnt[g])
`endif
      );
   end

   int unsigned ids [3] = '{1, 2, 3};
   int          vectors = 0;
   int          miscompares = 0;
   bit          act [3];
   bit          fin_out [3];
   int          exp_t [3] = '{0, 0, 0};
   int          exp_a [3] = '{0, 0, 0};
   bit          fast_e, dec_fast;
   longint      y16;
   int          cur_runs;

   function automatic bit pair_on(int unsigned rid, com_t c);
      if (rid >= replica_num - 1) return 1'b0;
      if (c == TWO) return (rid % 2) == 0;
      if (c == OR1) return (rid % 2) == 1;
      return 1'b0;
   endfunction

   // exp(-y) partial sum in Q.16, at most 31 terms, clamped to [0, 0xFFFF].
   function automatic longint exp_neg(longint yq, int runs);
      longint term = 65536;
      longint sum = 65536;
      int last = (runs > 31) ? 31 : runs;
      for (int n = 1; n <= last; n++) begin
         term = (term * yq) / 65536;
         term = (term * (65536 / n)) / 65536;
         sum  = (n % 2 == 1) ? sum - term : sum + term;
      end
      if (sum < 0) return 0;
      if (sum > 65535) return 65535;
      return sum;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string tag, int idx, logic [15:0] obs, logic [15:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s[id%0d] observed=%0h expected=%0h", tag, ids[idx], obs, expv);
      end
   endtask

   task automatic check_stats();
`ifdef EXCHANGE_STAT_EN
      for (int i = 0; i < 3; i++) begin
         check("test_cnt", i, tcnt[i], 16'(exp_t[i]));
         check("acc_cnt", i, acnt[i], 16'(exp_a[i]));
      end
`endif
   endtask

   task automatic count_decision(int i, bit d);
      exp_t[i]++;
      if (d) exp_a[i]++;
   endtask

   task automatic start(com_t c, logic [19:0] s, logic [19:0] f, logic [15:0] b, bit fin_too);
      longint prod;
      opt.com     = c;
      opt.mode    = 6'h2A;
      self_energy = s;
      folw_energy = f;
      delta_beta  = b;
      for (int i = 0; i < 3; i++) act[i] = pair_on(ids[i], c);
      y16 = 0;
      if (f >= s) begin
         fast_e = 1'b1; dec_fast = 1'b1;
      end else begin
         prod = (longint'(s) - longint'(f)) * longint'(b);
         if (prod >= 16384) begin
            fast_e = 1'b1; dec_fast = 1'b0;
         end else begin
            fast_e = 1'b0; dec_fast = 1'b0; y16 = prod * 16;
         end
      end
      exp_init = 1'b1;
      exp_fin  = fin_too;
      tick();
      exp_init = 1'b0;
      exp_fin  = 1'b0;
      cur_runs = 0;
      for (int i = 0; i < 3; i++) begin
         check("busy_init", i, 16'(busyv[i]), 16'(act[i]));
         check("out_init", i, 16'(outv[i]), 16'h0);
         fin_out[i] = 1'b0;
      end
   endtask

   task automatic load(bit fin_in_load);
      exp_fin = fin_in_load;
      tick();
      exp_fin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (act[i] && fast_e) begin
            check("out_fast", i, 16'(outv[i]), 16'(dec_fast));
            check("busy_fast", i, 16'(busyv[i]), 16'h0);
            count_decision(i, dec_fast);
            fin_out[i] = dec_fast;
         end else begin
            check("busy_load", i, 16'(busyv[i]), 16'(act[i]));
            check("out_load", i, 16'(outv[i]), 16'h0);
         end
      end
      check_stats();
   endtask

   task automatic do_runs(int n);
      for (int r = 1; r <= n; r++) begin
         exp_run   = 1'b1;
         exp_recip = 17'(65536 / r);
         tick();
         exp_run = 1'b0;
         cur_runs++;
      end
   endtask

   task automatic finish_test();
      bit sdec;
      exp_fin = 1'b1;
      tick();
      exp_fin = 1'b0;
      for (int i = 0; i < 3; i++)
         if (act[i] && !fast_e) begin
            check("out_decide", i, 16'(outv[i]), 16'h0);
            check("busy_decide", i, 16'(busyv[i]), 16'h1);
         end
      tick();
      sdec = longint'(rand_val) < exp_neg(y16, cur_runs);
      for (int i = 0; i < 3; i++) begin
         if (act[i] && !fast_e) begin
            fin_out[i] = sdec;
            count_decision(i, sdec);
         end
         check("out_final", i, 16'(outv[i]), 16'(fin_out[i]));
         check("busy_final", i, 16'(busyv[i]), 16'h0);
      end
      check_stats();
   endtask

   task automatic hold_check();
      exp_run = 1'b1;
      exp_fin = 1'b1;
      exp_recip = 17'h08000;
      tick();
      exp_run = 1'b0;
      exp_fin = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         check("out_hold", i, 16'(outv[i]), 16'(fin_out[i]));
         check("busy_hold", i, 16'(busyv[i]), 16'h0);
      end
   endtask

   task automatic run_test(com_t c, logic [19:0] s, logic [19:0] f, logic [15:0] b,
                           logic [15:0] rnd, int runs, bit fin_in_load);
      rand_val = rnd;
      start(c, s, f, b, 1'b0);
      load(fin_in_load);
      do_runs(runs);
      finish_test();
   endtask

   initial begin
      reset = 1'b1;
      opt.com = NONE; opt.mode = '0;
      self_energy = '0; folw_energy = '0; delta_beta = '0; rand_val = '0;
      exp_init = 1'b0; exp_run = 1'b0; exp_fin = 1'b0; exp_recip = '0;
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("out_reset", i, 16'(outv[i]), 16'h0);
         check("busy_reset", i, 16'(busyv[i]), 16'h0);
      end
      check_stats();

      // directed cases: fast accept, series accept/reject, clamp, inactive pairings
      run_test(TWO, 20'd100, 20'd120, 16'h0100, 16'h8000, 0, 1'b0);
      hold_check();
      run_test(TWO, 20'd120, 20'd100, 16'h0100, 16'h4000, 16, 1'b0);
      run_test(TWO, 20'd120, 20'd100, 16'h0100, 16'h5000, 16, 1'b0);
      run_test(OR1, 20'd1000, 20'd0, 16'h1000, 16'h0000, 4, 1'b0);
      run_test(NONE, 20'd50, 20'd10, 16'h0100, 16'h0000, 3, 1'b0);
      run_test(ALL, 20'd50, 20'd60, 16'h0100, 16'h0000, 0, 1'b0);

      // product boundary just under and at the y>=4 clamp; equal energies
      run_test(TWO, 20'd1, 20'd0, 16'h3FFF, 16'h0400, 34, 1'b0);
      run_test(TWO, 20'd1, 20'd0, 16'h3FFF, 16'h0500, 31, 1'b0);
      run_test(TWO, 20'd1, 20'd0, 16'h4000, 16'h0000, 5, 1'b0);
      run_test(OR1, 20'd500, 20'd500, 16'hFFFF, 16'hFFFF, 0, 1'b0);

      // exp_fin during LOAD is deferred to the next exp_fin in SERIES
      run_test(OR1, 20'd300, 20'd290, 16'h0200, 16'h3000, 10, 1'b1);

      // reset in the middle of a series: no decision, later exp_fin ignored
      rand_val = 16'h0000;
      start(TWO, 20'd120, 20'd100, 16'h0100, 1'b0);
      load(1'b0);
      do_runs(5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("out_midreset", i, 16'(outv[i]), 16'h0);
         check("busy_midreset", i, 16'(busyv[i]), 16'h0);
      end
`ifdef EXCHANGE_STAT_EN
      for (int i = 0; i < 3; i++) begin exp_t[i] = 0; exp_a[i] = 0; end
`endif
      exp_fin = 1'b1;
      tick();
      exp_fin = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         check("out_postreset", i, 16'(outv[i]), 16'h0);
         check("busy_postreset", i, 16'(busyv[i]), 16'h0);
         fin_out[i] = 1'b0;
      end
      check_stats();

      // restart mid-series, with exp_fin coincident with exp_init
      rand_val = 16'h2000;
      start(TWO, 20'd120, 20'd100, 16'h0100, 1'b0);
      load(1'b0);
      do_runs(3);
      start(TWO, 20'd200, 20'd190, 16'h0300, 1'b1);
      load(1'b0);
      do_runs(12);
      finish_test();
      hold_check();

      // restart into an inactive pairing drops busy
      start(TWO, 20'd120, 20'd100, 16'h0100, 1'b0);
      load(1'b0);
      do_runs(2);
      start(NONE, 20'd120, 20'd100, 16'h0100, 1'b0);
      hold_check();

      // randomized tests against the reference model
      for (int t = 0; t < 40; t++) begin
         com_t        c;
         logic [19:0] s, f;
         int unsigned d;
         case ($urandom_range(0, 3))
            0:       c = TWO;
            1:       c = OR1;
            2:       c = TWO;
            default: c = NONE;
         endcase
         s = 20'($urandom_range(0, 4095));
         if ($urandom_range(0, 3) == 0) begin
            f = 20'($urandom_range(0, 4095));
         end else begin
            d = $urandom_range(0, 40);
            f = (s > 20'(d)) ? s - 20'(d) : 20'd0;
         end
         run_test(c, s, f, 16'($urandom_range(0, 16'h2000)), 16'($urandom),
                  int'($urandom_range(0, 34)), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
